// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
// Holds XLEN, the RV32 funct3 load/store size codes and the FSM state encoding.
package dmem_resp_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: store byte enables and shifted data, load extract/extend.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module dmem_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      mode,
  input  logic            write,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_word,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] load_data,
  output logic            err
);

  logic [1:0]      off;
  logic [XLEN-1:0] lane;

  always_comb begin
    off       = 2'b00;
    byte_en   = 4'b0000;
    err       = 1'b0;
    load_data = '0;
    wdata_sh  = '0;
    lane      = '0;
    // Without the trap option, half/word offsets are silently rounded down.
    case (mode)
      MEM_B, MEM_BU: begin
        off     = addr_lo;
        byte_en = 4'b0001 << addr_lo;
      end
      MEM_H, MEM_HU: begin
        off     = {addr_lo[1], 1'b0};
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      MEM_W:   byte_en = 4'b1111;
      default: err = 1'b1;
    endcase
    if (write && (mode == MEM_BU || mode == MEM_HU)) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((mode == MEM_H || mode == MEM_HU) && addr_lo[0]) err = 1'b1;
    if (mode == MEM_W && addr_lo != 2'b00) err = 1'b1;
`endif
    wdata_sh = wdata << {off, 3'b000};
    lane     = mem_word >> {off, 3'b000};
    case (mode)
      MEM_B:   load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      MEM_BU:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      MEM_H:   load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      MEM_HU:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      MEM_W:   load_data = lane;
      default: load_data = '0;
    endcase
    if (err || write) load_data = '0;
    if (err || !write) byte_en = 4'b0000;
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-port data memory responder: IDLE -> ACCESS (WAIT_CYCLES+1) -> RESP -> IDLE.
// Optional macro DMEM_MISALIGN_TRAP_EN (in dmem_align) turns misaligned half/word into errors.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_mode,
  input  logic            req_write,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [1:0]      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid and its payload stay stable until that edge, and valid never waits on ready.

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [2:0]            mode_q;
  logic                  write_q;
  logic                  fmt_q;
  logic [XLEN-1:0]       mem_q;
  logic                  mem_en;
  logic [3:0]            byte_en;
  logic [XLEN-1:0]       wdata_sh;
  logic [XLEN-1:0]       load_data;
  logic                  err;
  logic                  unused_addr_hi;

  logic [XLEN-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign unused_addr_hi = ^req_addr[XLEN-1:DEPTH_LOG2+2];
  assign state_dbg      = state_q;
  assign mem_en         = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req_valid && req_ready) begin
        state_d = ST_ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: if (resp_valid && resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      req_ready <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= MEM_W;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == ST_IDLE);
      if (req_valid && req_ready) begin
        addr_q  <= req_addr[DEPTH_LOG2+1:0];
        wdata_q <= req_wdata;
        mode_q  <= req_mode;
        write_q <= req_write;
      end
    end
  end

  dmem_align u_align (
    .addr_lo   (addr_q[1:0]),
    .mode      (mode_q),
    .write     (write_q),
    .wdata     (wdata_q),
    .mem_word  (mem_q),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .load_data (load_data),
    .err       (err)
  );

  // Not reset: contents survive rst; a reset in ACCESS forces IDLE so mem_en never fires.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[addr_q[DEPTH_LOG2+1:2]][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
      mem_q <= mem[addr_q[DEPTH_LOG2+1:2]];
    end
  end

  // The RAM word lands one edge after mem_en; fmt_q marks that edge to format the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmt_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      fmt_q <= mem_en;
      if (fmt_q) begin
        resp_valid <= 1'b1;
        resp_rdata <= load_data;
        resp_err   <= err;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a WAIT_CYCLES=0 instance for function and back-pressure,
// and a WAIT_CYCLES=3 instance for latency and reset-during-ACCESS behaviour.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_mode = 3'b010;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  state_dbg;

  logic        s_req_valid = 1'b0, s_req_ready, s_req_write = 1'b0;
  logic [31:0] s_req_addr = '0, s_req_wdata = '0;
  logic [2:0]  s_req_mode = 3'b010;
  logic        s_resp_valid, s_resp_ready = 1'b1, s_resp_err;
  logic [31:0] s_resp_rdata;
  logic [1:0]  s_state_dbg;

  dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .state_dbg(state_dbg)
  );

  dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_slow (
    .clk(clk), .rst(s_rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_mode(s_req_mode), .req_write(s_req_write),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_rdata(s_resp_rdata),
    .resp_err(s_resp_err), .state_dbg(s_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          acc_q[$];
  logic [31:0] s_exp_q[$];
  logic        s_exp_err_q[$];
  int          s_acc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                       input logic w, input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    req_addr = a; req_wdata = d; req_mode = m; req_write = w; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      fail("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(er);
    exp_err_q.push_back(ee);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue_s(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                         input logic w, input logic [31:0] er, input logic ee, input logic push);
    int n = 0;
    @(negedge clk);
    s_req_addr = a; s_req_wdata = d; s_req_mode = m; s_req_write = w; s_req_valid = 1'b1;
    while (!s_req_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_req_ready) begin
      fail("slow_accept_timeout");
      s_req_valid = 1'b0;
      return;
    end
    if (push) begin
      s_exp_q.push_back(er);
      s_exp_err_q.push_back(ee);
      s_acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1 s_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid || s_exp_q.size() != 0 || s_resp_valid) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) fail("drain_timeout");
  endtask

  // ---------------- monitors ----------------
  logic        m_seen = 1'b0, held_e;
  logic [31:0] held_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (!m_seen) begin
          m_seen = 1'b1; held_r = resp_rdata; held_e = resp_err;
          if (acc_q.size() == 0) fail("resp_without_request");
          else check("latency_w0", cyc - acc_q.pop_front(), 2);
        end else begin
          check("hold_rdata", resp_rdata, held_r);
          check("hold_err", {31'd0, resp_err}, {31'd0, held_e});
        end
        check("req_ready_in_resp", {31'd0, req_ready}, 0);
        if (resp_ready) begin
          if (exp_q.size() == 0) fail("resp_without_expect");
          else begin
            check("rdata", resp_rdata, exp_q.pop_front());
            check("err", {31'd0, resp_err}, {31'd0, exp_err_q.pop_front()});
          end
          m_seen = 1'b0;
        end
      end else begin
        check("idle_rdata_zero", resp_rdata, 0);
        check("idle_err_zero", {31'd0, resp_err}, 0);
      end
    end
  end

  logic s_seen = 1'b0;

  always @(negedge clk) begin
    if (s_rst) s_seen = 1'b0;
    else if (s_resp_valid) begin
      if (!s_seen) begin
        s_seen = 1'b1;
        if (s_acc_q.size() == 0) fail("slow_resp_without_request");
        else check("latency_w3", cyc - s_acc_q.pop_front(), 5);
      end
      if (s_resp_ready) begin
        if (s_exp_q.size() == 0) fail("slow_resp_without_expect");
        else begin
          check("slow_rdata", s_resp_rdata, s_exp_q.pop_front());
          check("slow_err", {31'd0, s_resp_err}, {31'd0, s_exp_err_q.pop_front()});
        end
        s_seen = 1'b0;
      end
    end else begin
      check("slow_idle_rdata_zero", s_resp_rdata, 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] lw11_exp;
  logic        lw11_err;

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    lw11_exp = 32'h0; lw11_err = 1'b1;
`else
    lw11_exp = 32'h80ADBEEF; lw11_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 1);
    check("reset_resp_valid", {31'd0, resp_valid}, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_state", {30'd0, state_dbg}, 0);

    issue(32'h10, 32'hDEADBEEF, MEM_W,  1'b1, 32'h0,        1'b0);
    issue(32'h10, 32'h0,        MEM_W,  1'b0, 32'hDEADBEEF, 1'b0);
    issue(32'h13, 32'h80,       MEM_B,  1'b1, 32'h0,        1'b0);
    issue(32'h13, 32'h0,        MEM_B,  1'b0, 32'hFFFFFF80, 1'b0);
    issue(32'h13, 32'h0,        MEM_BU, 1'b0, 32'h00000080, 1'b0);
    issue(32'h10, 32'h0,        MEM_W,  1'b0, 32'h80ADBEEF, 1'b0);
    issue(32'h12, 32'h0,        MEM_H,  1'b0, 32'hFFFF80AD, 1'b0);
    issue(32'h12, 32'h0,        MEM_HU, 1'b0, 32'h000080AD, 1'b0);
    issue(32'h11, 32'h0,        MEM_W,  1'b0, lw11_exp,     lw11_err);
    issue(32'h10, 32'h0,        3'b111, 1'b0, 32'h0,        1'b1);
    issue(32'h10, 32'h55,       MEM_BU, 1'b1, 32'h0,        1'b1);
    issue(32'h10, 32'hFFFFFFFF, 3'b011, 1'b1, 32'h0,        1'b1);
    issue(32'h10, 32'h0,        MEM_W,  1'b0, 32'h80ADBEEF, 1'b0);
    issue(32'h14, 32'h11223344, MEM_W,  1'b1, 32'h0,        1'b0);
    issue(32'h16, 32'hA5A51234, MEM_H,  1'b1, 32'h0,        1'b0);
    issue(32'h14, 32'h0,        MEM_W,  1'b0, 32'h12343344, 1'b0);
    issue(32'h14, 32'h0,        MEM_H,  1'b0, 32'h00003344, 1'b0);
    issue(32'h15, 32'h0,        MEM_B,  1'b0, 32'h00000033, 1'b0);
    issue(32'h17, 32'h0,        MEM_BU, 1'b0, 32'h00000012, 1'b0);
    issue(32'h1010, 32'h0BADF00D, MEM_W, 1'b1, 32'h0,       1'b0);
    issue(32'h10, 32'h0,        MEM_W,  1'b0, 32'h0BADF00D, 1'b0);
    drain();

    // Back-pressure: response held for five edges with resp_ready low.
    resp_ready = 1'b0;
    issue(32'h10, 32'h0, MEM_W, 1'b0, 32'h0BADF00D, 1'b0);
    repeat (7) @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();

    // Slow instance: latency, then reset in the middle of ACCESS drops the store.
    issue_s(32'h20, 32'hCAFEF00D, MEM_W, 1'b1, 32'h0, 1'b0, 1'b1);
    drain();
    issue_s(32'h20, 32'h12345678, MEM_W, 1'b1, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 s_rst = 1'b1;
    #1;
    check("rst_access_valid", {31'd0, s_resp_valid}, 0);
    check("rst_access_rdata", s_resp_rdata, 0);
    check("rst_access_err", {31'd0, s_resp_err}, 0);
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    check("slow_ready_after_rst", {31'd0, s_req_ready}, 1);
    issue_s(32'h20, 32'h0, MEM_W, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    if (exp_q.size() != 0 || s_exp_q.size() != 0) fail("scoreboard_not_empty");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
